// File: rtl/switch_input_reader_if.sv
// Submission channel between the switch/button front end and the puzzle logic.
// A snapshot transfers on any clock edge where valid and ready are both high.
interface switch_input_reader_if #(
  parameter int N_SW = 18
);
  logic            submit_valid;
  logic [N_SW-1:0] submit_data;
  logic            submit_ready;

  modport master (
    output submit_valid,
    output submit_data,
    input  submit_ready
  );

  modport slave (
    input  submit_valid,
    input  submit_data,
    output submit_ready
  );
endinterface

// File: rtl/switch_input_reader.sv
// DE2 switch/button front end: synchronize, debounce, publish stable switches and
// turn each debounced button press into exactly one valid/ready submission.

module sir_debounce #(
  parameter int W               = 18,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] stable_o,
  output logic [W-1:0] stable_nxt_o
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     sync1_q, sync2_q;
  logic [W-1:0]     cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     stable_q, stable_d;

  // Any bit differing from the candidate restarts the whole window.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o     = stable_q;
  assign stable_nxt_o = stable_d;
endmodule

// Button FSM states:
//   state | meaning
//   IDLE  | debounced button released, waiting for a press
//   HELD  | press already reported, waiting for release
module switch_input_reader #(
  parameter int N_SW            = 18,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [N_SW-1:0]         sw_raw_i,
  input  logic                    btn_raw_i,
  output logic [N_SW-1:0]         sw_stable_o,
  output logic                    sw_changed_o,
  output logic                    overrun_o,
  switch_input_reader_if.master   sub_if
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  logic [N_SW-1:0] sw_stable, sw_stable_nxt;
  logic            btn_stable, btn_stable_nxt;

  logic [0:0]      state_q, state_d;
  logic            valid_q, valid_d;
  logic [N_SW-1:0] data_q, data_d;
  logic            overrun_q, overrun_d;
  logic            changed_q, changed_d;
  logic            press;
  logic            xfer;

  sir_debounce #(
    .W               (N_SW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_sw_db (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .raw_i        (sw_raw_i),
    .stable_o     (sw_stable),
    .stable_nxt_o (sw_stable_nxt)
  );

  sir_debounce #(
    .W               (1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn_db (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .raw_i        (btn_raw_i),
    .stable_o     (btn_stable),
    .stable_nxt_o (btn_stable_nxt)
  );

  // The press lands on the same edge btn_stable rises, so it is decoded from
  // the debouncer's next-state value.
  always_comb begin
    state_d = state_q;
    press   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_stable_nxt && !btn_stable) begin
          state_d = ST_HELD;
          press   = 1'b1;
        end
      end
      ST_HELD: begin
        if (!btn_stable_nxt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign xfer = valid_q && sub_if.submit_ready;

  // Snapshot is taken from the published vector as it stood before this edge.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    if (press && (!valid_q || xfer)) begin
      valid_d = 1'b1;
      data_d  = sw_stable;
    end else if (press) begin
      overrun_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  assign changed_d = (sw_stable_nxt != sw_stable);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
      changed_q <= changed_d;
    end
  end

  assign sw_stable_o         = sw_stable;
  assign sw_changed_o        = changed_q;
  assign overrun_o           = overrun_q;
  assign sub_if.submit_valid = valid_q;
  assign sub_if.submit_data  = data_q;
endmodule

// File: tb/tb_switch_input_reader.sv
// Bench for switch_input_reader: a sliding-window model of debounce plus a
// submission model, compared every cycle, with directed literal checkpoints.
module tb_switch_input_reader;
  localparam int N  = 18;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  sw_raw;
  logic          btn_raw;
  logic [N-1:0]  sw_stable;
  logic          sw_changed;
  logic          overrun;

  switch_input_reader_if #(.N_SW(N)) sub_if ();

  switch_input_reader #(
    .N_SW            (N),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (CW)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .sw_raw_i     (sw_raw),
    .btn_raw_i    (btn_raw),
    .sw_stable_o  (sw_stable),
    .sw_changed_o (sw_changed),
    .overrun_o    (overrun),
    .sub_if       (sub_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a value is accepted once the synchronized input (raw delayed two
  // edges) has shown it on D+1 consecutive edges.
  logic [N-1:0] sw_hist [0:D+2];
  logic         btn_hist[0:D+2];
  logic [N-1:0] m_sw, m_data;
  logic         m_chg, m_btn, m_valid, m_ovr;
  bit           armed = 0;

  always @(posedge clk) begin : model
    logic [N-1:0] nsw;
    logic         nbtn;
    bit           steady, press, xfer;
    armed = 1;
    if (reset) begin
      for (int k = 0; k <= D + 2; k++) begin
        sw_hist[k]  = '0;
        btn_hist[k] = 1'b0;
      end
      m_sw = '0; m_data = '0; m_chg = 0; m_btn = 0; m_valid = 0; m_ovr = 0;
    end else begin
      for (int k = D + 2; k > 0; k--) begin
        sw_hist[k]  = sw_hist[k-1];
        btn_hist[k] = btn_hist[k-1];
      end
      sw_hist[0]  = sw_raw;
      btn_hist[0] = btn_raw;
      nsw = m_sw;
      steady = 1;
      for (int k = 3; k <= D + 2; k++) if (sw_hist[k] !== sw_hist[2]) steady = 0;
      if (steady) nsw = sw_hist[2];
      nbtn = m_btn;
      steady = 1;
      for (int k = 3; k <= D + 2; k++) if (btn_hist[k] !== btn_hist[2]) steady = 0;
      if (steady) nbtn = btn_hist[2];
      press = nbtn && !m_btn;
      xfer  = m_valid && sub_if.submit_ready;
      if (press && (!m_valid || xfer)) begin
        m_valid = 1;
        m_data  = m_sw;
      end else if (press) begin
        m_ovr = 1;
      end else if (xfer) begin
        m_valid = 0;
      end
      m_chg = (nsw != m_sw);
      m_sw  = nsw;
      m_btn = nbtn;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("m_sw_stable", 32'(sw_stable), 32'(m_sw));
      check("m_sw_changed", 32'(sw_changed), 32'(m_chg));
      check("m_submit_valid", 32'(sub_if.submit_valid), 32'(m_valid));
      if (m_valid) check("m_submit_data", 32'(sub_if.submit_data), 32'(m_data));
      check("m_overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  int pulses;
  int vcount;
  logic [N-1:0] vdata;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task tick_count(input int n);
    repeat (n) begin
      @(negedge clk);
      if (sw_changed) pulses++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout reached without completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; sw_raw = '0; btn_raw = 1'b0; sub_if.submit_ready = 1'b0;
    tick(3);
    check("rst_sw_stable", 32'(sw_stable), 32'h0);
    check("rst_sw_changed", 32'(sw_changed), 32'h0);
    check("rst_valid", 32'(sub_if.submit_valid), 32'h0);
    check("rst_data", 32'(sub_if.submit_data), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);

    reset = 1'b0; sw_raw = 18'h00005;
    tick(6);
    check("sw_edge6", 32'(sw_stable), 32'h0);
    tick(1);
    check("sw_edge7", 32'(sw_stable), 32'h5);
    check("chg_edge7", 32'(sw_changed), 32'h1);
    tick(1);
    check("chg_edge8", 32'(sw_changed), 32'h0);

    // bounce on bit 0
    sw_raw = '0; tick(10);
    pulses = 0;
    sw_raw = 18'h1; tick_count(2);
    sw_raw = 18'h0; tick_count(2);
    sw_raw = 18'h1; tick_count(6);
    check("bounce_edge6", 32'(sw_stable), 32'h0);
    tick_count(1);
    check("bounce_edge7", 32'(sw_stable), 32'h1);
    tick_count(3);
    check("bounce_pulses", 32'(pulses), 32'h1);

    // held press with ready high
    sw_raw = 18'h3FFFF; tick(10);
    check("sub_sw", 32'(sw_stable), 32'h3FFFF);
    sub_if.submit_ready = 1'b1; btn_raw = 1'b1;
    vcount = 0; vdata = '0;
    repeat (20) begin
      @(negedge clk);
      if (sub_if.submit_valid) begin vcount++; vdata = sub_if.submit_data; end
    end
    check("sub_count", 32'(vcount), 32'h1);
    check("sub_data", 32'(vdata), 32'h3FFFF);
    btn_raw = 1'b0; tick(10);

    // back-pressure
    sub_if.submit_ready = 1'b0;
    btn_raw = 1'b1; tick(8); btn_raw = 1'b0; tick(8);
    check("bp_valid1", 32'(sub_if.submit_valid), 32'h1);
    check("bp_ovr1", 32'(overrun), 32'h0);
    sw_raw = 18'h12345;
    btn_raw = 1'b1; tick(8); btn_raw = 1'b0; tick(8);
    check("bp_sw", 32'(sw_stable), 32'h12345);
    check("bp_valid2", 32'(sub_if.submit_valid), 32'h1);
    check("bp_data2", 32'(sub_if.submit_data), 32'h3FFFF);
    check("bp_ovr2", 32'(overrun), 32'h1);
    sub_if.submit_ready = 1'b1; tick(1);
    check("bp_drop", 32'(sub_if.submit_valid), 32'h0);
    sub_if.submit_ready = 1'b0; tick(1);
    check("bp_ovr_sticky", 32'(overrun), 32'h1);

    // reset with a pending submission and a switch change mid-debounce
    btn_raw = 1'b1; tick(8); btn_raw = 1'b0; tick(8);
    check("mid_valid", 32'(sub_if.submit_valid), 32'h1);
    sw_raw = 18'h0; tick(4);
    reset = 1'b1; sw_raw = 18'h3FFFF; btn_raw = 1'b1; tick(1);
    check("mid_rst_sw", 32'(sw_stable), 32'h0);
    check("mid_rst_valid", 32'(sub_if.submit_valid), 32'h0);
    check("mid_rst_data", 32'(sub_if.submit_data), 32'h0);
    check("mid_rst_ovr", 32'(overrun), 32'h0);
    reset = 1'b0; tick(6);
    check("rerun_edge6_sw", 32'(sw_stable), 32'h0);
    check("rerun_edge6_valid", 32'(sub_if.submit_valid), 32'h0);
    tick(1);
    check("rerun_edge7_sw", 32'(sw_stable), 32'h3FFFF);
    check("rerun_edge7_valid", 32'(sub_if.submit_valid), 32'h1);
    check("rerun_edge7_data", 32'(sub_if.submit_data), 32'h0);

    // press lands on the same edge as the transfer of the pending submission
    btn_raw = 1'b0; tick(10);
    btn_raw = 1'b1; tick(6);
    sub_if.submit_ready = 1'b1; tick(1);
    check("simul_valid", 32'(sub_if.submit_valid), 32'h1);
    check("simul_data", 32'(sub_if.submit_data), 32'h3FFFF);
    check("simul_ovr", 32'(overrun), 32'h0);
    sub_if.submit_ready = 1'b0; tick(1);
    check("simul_hold", 32'(sub_if.submit_valid), 32'h1);
    btn_raw = 1'b0; tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/switch_input_reader.md
# switch_input_reader

Input-side front end for the LED/switch puzzle on the DE2 board: the LED puzzle block drives LEDR/LEDG; this block reads the 18 slide switches and the submit push-button. It synchronizes and debounces the raw pins and publishes a stable switch vector. Each button press becomes a single valid/ready submission carrying a switch snapshot, so the puzzle logic never sees metastable, bouncing or repeated inputs.

## Interface
- N_SW, 18: number of switch inputs.
- DEBOUNCE_CYCLES, 1_000_000: cycles an input must hold steady before acceptance (20 ms at 50 MHz); legal range ≥ 2.
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

- CLOCK_50  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sw_raw  input  N_SW  asynchronous slide-switch pins.
- btn_raw  input  1  asynchronous submit button, already active-high (pressed = 1).
- sw_stable  output  N_SW  debounced switch vector.
- sw_changed  output  1  one-cycle pulse when sw_stable updates to a different value.
- submit_valid  output  1  submission pending.
- submit_data  output  N_SW  switch snapshot for the pending submission; held while submit_valid = 1.
- submit_ready  input  1  consumer accepts the submission when high with submit_valid.
- overrun  output  1  sticky: a press arrived while a submission was still pending.

## Operation
- Synchronizer: two flops on every sw_raw bit and on btn_raw. Both stages reset to 0.
- Switch debounce: one shared vector debouncer holding candidate register `cand` (N_SW) and counter `cnt` (CNT_W).
  - If sync output ≠ cand: cand ← sync, cnt ← 0.
  - Else if cnt = DEBOUNCE_CYCLES−1: sw_stable ← cand. sw_changed = 1 for that cycle only if the value differs. cnt holds.
  - Else: cnt ← cnt+1.
  - Any bit change restarts the whole window.
- Button debounce: an identical one-bit debouncer produces btn_stable.
- Button FSM, states IDLE and HELD:
  - IDLE → HELD on the edge where btn_stable goes 0→1; this is a press event.
  - HELD → IDLE on the edge where btn_stable goes 1→0.
  - Exactly one press event per physical press, regardless of hold length.
- Submission handshake:
  - Transfer occurs on an edge with submit_valid & submit_ready.
  - On a press event with no pending submission (submit_valid = 0, or a transfer on the same edge): submit_valid ← 1 and submit_data ← sw_stable as it stood before that edge.
  - On a press event while submit_valid = 1 and no transfer: overrun ← 1. submit_data and submit_valid are unchanged; the press is dropped.
  - Transfer with no press event: submit_valid ← 0. submit_data holds its last value.
  - submit_valid never drops without a transfer; submit_data is stable while valid.
- overrun clears only on reset.
- Reset (any cycle, including mid-debounce or with a pending submission):
  - sync flops, cand, cnt, sw_stable, btn_stable, submit_valid, submit_data, sw_changed and overrun all go to 0.
  - FSM goes to IDLE. Any pending submission is discarded.
  - A switch held at 1 through reset is re-debounced from scratch after reset.

## Timing
- Count edges from the first rising edge that samples a new raw value as edge 1. With raw then steady, sw_stable / btn_stable update on edge DEBOUNCE_CYCLES+3.
- The press event, submit_valid rise and submit_data capture occur on that same edge as btn_stable rising.
- A raw pulse or glitch whose synchronized value is steady for fewer than DEBOUNCE_CYCLES+1 consecutive cycles produces no change.
- submit_ready has no combinational path to any output. submit_valid deasserts on the edge after a transfer (registered).
- All outputs are registered.

## Test plan
(DEBOUNCE_CYCLES = 4 throughout.)
- Reset → all outputs 0. Then sw_raw = 18'h00005 held → sw_stable = 18'h00005 on edge 7 and sw_changed high for exactly that one cycle.
- Bounce: sw_raw[0] toggles 0/1/0/1 every 2 cycles, then held at 1 → sw_stable[0] changes only 7 edges after the final toggle. No intermediate sw_changed pulse.
- Submit: sw_stable = 18'h3FFFF, btn_raw held high for 20 cycles with submit_ready = 1 → exactly one valid cycle with submit_data = 18'h3FFFF. No second submission while held.
- Back-pressure: submit_ready = 0, two separate debounced presses → first submission stays valid with unchanged data, overrun = 1 after the second press. Then ready = 1 → one transfer, valid drops, overrun stays 1.
- Simultaneous event: the press event lands on the same edge as a transfer of the pending submission → submit_valid stays 1 with new data, overrun stays 0.
- Reset mid-operation: assert reset while submit_valid = 1 and mid-debounce → all outputs 0 the next edge. After release, raw inputs held at 1 require the full 7 edges again.
